// File: rtl/pcie_us_axis_rc_tag_demux.sv
// Requester-completion demux: routes each RC frame to the output chosen by its tag,
// dropping errored, out-of-range or externally dropped frames behind a skid buffer.
module pcie_us_axis_rc_tag_demux #(
  parameter int unsigned M_COUNT                 = 4,
  parameter int unsigned AXIS_PCIE_DATA_WIDTH    = 256,
  parameter int unsigned AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int unsigned AXIS_PCIE_RC_USER_WIDTH = (AXIS_PCIE_DATA_WIDTH < 512) ? 75 : 161,
  parameter int unsigned TAG_SEL_LSB             = 0,
  parameter int unsigned DROP_ERR                = 1,
  parameter int unsigned CNT_WIDTH               = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [AXIS_PCIE_DATA_WIDTH-1:0]             s_axis_rc_tdata,
  input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]             s_axis_rc_tkeep,
  input  logic                                        s_axis_rc_tvalid,
  output logic                                        s_axis_rc_tready,
  input  logic                                        s_axis_rc_tlast,
  input  logic [AXIS_PCIE_RC_USER_WIDTH-1:0]          s_axis_rc_tuser,
  output logic [M_COUNT*AXIS_PCIE_DATA_WIDTH-1:0]     m_axis_rc_tdata,
  output logic [M_COUNT*AXIS_PCIE_KEEP_WIDTH-1:0]     m_axis_rc_tkeep,
  output logic [M_COUNT-1:0]                          m_axis_rc_tvalid,
  input  logic [M_COUNT-1:0]                          m_axis_rc_tready,
  output logic [M_COUNT-1:0]                          m_axis_rc_tlast,
  output logic [M_COUNT*AXIS_PCIE_RC_USER_WIDTH-1:0]  m_axis_rc_tuser,
  output logic [7:0]                                  tag,
  input  logic                                        enable,
  input  logic                                        drop,
  output logic                                        stat_drop,
  output logic [CNT_WIDTH-1:0]                        drop_count,
  output logic [CNT_WIDTH-1:0]                        err_count
);

  localparam int unsigned CL_M_COUNT = $clog2(M_COUNT);
  localparam int unsigned DW         = AXIS_PCIE_DATA_WIDTH;
  localparam int unsigned KW         = AXIS_PCIE_KEEP_WIDTH;
  localparam int unsigned UW         = AXIS_PCIE_RC_USER_WIDTH;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                state_q, state_d;
  logic [CL_M_COUNT-1:0] sel_q, sel_d;
  logic                  tready_q, tready_d;
  logic                  stat_drop_q, stat_drop_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [M_COUNT-1:0]    out_valid_q, out_valid_d;
  logic [M_COUNT-1:0]    temp_valid_q, temp_valid_d;
  logic [DW-1:0]         out_data_q, out_data_d, temp_data_q, temp_data_d;
  logic [KW-1:0]         out_keep_q, out_keep_d, temp_keep_q, temp_keep_d;
  logic                  out_last_q, out_last_d, temp_last_q, temp_last_d;
  logic [UW-1:0]         out_user_q, out_user_d, temp_user_q, temp_user_d;

  logic                  s_hs, err, dropf, fwd_hs, drop_evt, err_evt;
  logic                  ready_sel, out_ready_early;
  logic [CL_M_COUNT-1:0] idx, fwd_sel;
  logic [M_COUNT-1:0]    int_valid;

  assign s_axis_rc_tready = tready_q & enable;
  assign s_hs             = s_axis_rc_tvalid & s_axis_rc_tready;
  assign tag              = s_axis_rc_tdata[71:64];
  assign idx              = s_axis_rc_tdata[64+TAG_SEL_LSB +: CL_M_COUNT];
  assign err              = |s_axis_rc_tdata[15:12];
  assign dropf            = drop | (32'(idx) >= M_COUNT) | ((DROP_ERR != 0) & err);

  // Frame FSM: routing and drop decision are taken on beat 0 and held to tlast
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    fwd_hs   = 1'b0;
    fwd_sel  = sel_q;
    drop_evt = 1'b0;
    err_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_hs) begin
          if (dropf) begin
            drop_evt = 1'b1;
            err_evt  = (DROP_ERR != 0) & err;
            state_d  = s_axis_rc_tlast ? IDLE : DROP;
          end else begin
            fwd_hs  = 1'b1;
            fwd_sel = idx;
            sel_d   = idx;
            state_d = s_axis_rc_tlast ? IDLE : FWD;
          end
        end
      end
      FWD: begin
        if (s_hs) begin
          fwd_hs = 1'b1;
          if (s_axis_rc_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        if (s_hs && s_axis_rc_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_valid       = fwd_hs ? (M_COUNT'(1) << fwd_sel) : '0;
  assign ready_sel       = |(out_valid_q & m_axis_rc_tready);
  assign out_ready_early = ready_sel | (~|temp_valid_q & (~|out_valid_q | ~fwd_hs));

  // Input ready, drop statistics and saturating counters
  always_comb begin
    tready_d     = out_ready_early | (state_d == DROP);
    stat_drop_d  = drop_evt;
    drop_count_d = drop_count_q;
    err_count_d  = err_count_q;
    if (drop_evt && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_WIDTH'(1);
    if (err_evt && (err_count_q != '1))   err_count_d  = err_count_q + CNT_WIDTH'(1);
  end

  // Skid buffer: temp drains into the output register before any new beat
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    temp_valid_d = temp_valid_q;
    temp_data_d  = temp_data_q;
    temp_keep_d  = temp_keep_q;
    temp_last_d  = temp_last_q;
    temp_user_d  = temp_user_q;
    if (ready_sel || ~|out_valid_q) begin
      if (|temp_valid_q) begin
        out_valid_d = temp_valid_q;
        out_data_d  = temp_data_q;
        out_keep_d  = temp_keep_q;
        out_last_d  = temp_last_q;
        out_user_d  = temp_user_q;
        temp_valid_d = int_valid;
        if (fwd_hs) begin
          temp_data_d = s_axis_rc_tdata;
          temp_keep_d = s_axis_rc_tkeep;
          temp_last_d = s_axis_rc_tlast;
          temp_user_d = s_axis_rc_tuser;
        end
      end else begin
        out_valid_d = int_valid;
        out_data_d  = s_axis_rc_tdata;
        out_keep_d  = s_axis_rc_tkeep;
        out_last_d  = s_axis_rc_tlast;
        out_user_d  = s_axis_rc_tuser;
      end
    end else if (fwd_hs) begin
      temp_valid_d = int_valid;
      temp_data_d  = s_axis_rc_tdata;
      temp_keep_d  = s_axis_rc_tkeep;
      temp_last_d  = s_axis_rc_tlast;
      temp_user_d  = s_axis_rc_tuser;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      tready_q     <= 1'b0;
      stat_drop_q  <= 1'b0;
      drop_count_q <= '0;
      err_count_q  <= '0;
      out_valid_q  <= '0;
      temp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tready_q     <= tready_d;
      stat_drop_q  <= stat_drop_d;
      drop_count_q <= drop_count_d;
      err_count_q  <= err_count_d;
      out_valid_q  <= out_valid_d;
      temp_valid_q <= temp_valid_d;
    end
  end

  // Payload registers carry no reset; their valids qualify them
  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    out_keep_q  <= out_keep_d;
    out_last_q  <= out_last_d;
    out_user_q  <= out_user_d;
    temp_data_q <= temp_data_d;
    temp_keep_q <= temp_keep_d;
    temp_last_q <= temp_last_d;
    temp_user_q <= temp_user_d;
  end

  assign m_axis_rc_tvalid = out_valid_q;
  assign m_axis_rc_tdata  = {M_COUNT{out_data_q}};
  assign m_axis_rc_tkeep  = {M_COUNT{out_keep_q}};
  assign m_axis_rc_tlast  = {M_COUNT{out_last_q}};
  assign m_axis_rc_tuser  = {M_COUNT{out_user_q}};
  assign stat_drop        = stat_drop_q;
  assign drop_count       = drop_count_q;
  assign err_count        = err_count_q;

endmodule

// File: tb/tb_pcie_us_axis_rc_tag_demux.sv
// Directed bench for the tag demux: 3 outputs so tag 3 is out of range, 4-bit counters.
module tb_pcie_us_axis_rc_tag_demux;

  localparam int unsigned M  = 3;
  localparam int unsigned DW = 128;
  localparam int unsigned KW = 4;
  localparam int unsigned UW = 75;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_tdata;
  logic [KW-1:0]   s_tkeep;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [UW-1:0]   s_tuser;
  logic [M*DW-1:0] m_tdata;
  logic [M*KW-1:0] m_tkeep;
  logic [M-1:0]    m_tvalid;
  logic [M-1:0]    m_tready;
  logic [M-1:0]    m_tlast;
  logic [M*UW-1:0] m_tuser;
  logic [7:0]      tag;
  logic            enable;
  logic            drop;
  logic            stat_drop;
  logic [CW-1:0]   drop_count;
  logic [CW-1:0]   err_count;

  int total = 0;
  int bad   = 0;
  int w;
  logic          cap_en = 1'b0;
  logic [DW-1:0] cap[$];
  logic [DW-1:0] exp_d[4];

  always #5 clk = ~clk;

  pcie_us_axis_rc_tag_demux #(
    .M_COUNT(M), .AXIS_PCIE_DATA_WIDTH(DW), .AXIS_PCIE_KEEP_WIDTH(KW),
    .AXIS_PCIE_RC_USER_WIDTH(UW), .TAG_SEL_LSB(0), .DROP_ERR(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_rc_tdata(s_tdata), .s_axis_rc_tkeep(s_tkeep), .s_axis_rc_tvalid(s_tvalid),
    .s_axis_rc_tready(s_tready), .s_axis_rc_tlast(s_tlast), .s_axis_rc_tuser(s_tuser),
    .m_axis_rc_tdata(m_tdata), .m_axis_rc_tkeep(m_tkeep), .m_axis_rc_tvalid(m_tvalid),
    .m_axis_rc_tready(m_tready), .m_axis_rc_tlast(m_tlast), .m_axis_rc_tuser(m_tuser),
    .tag(tag), .enable(enable), .drop(drop), .stat_drop(stat_drop),
    .drop_count(drop_count), .err_count(err_count)
  );

  // Beats that will transfer on output 1 at the coming rising edge
  always @(negedge clk) begin
    if (cap_en && m_tvalid[1] && m_tready[1]) cap.push_back(m_tdata[DW +: DW]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk(input logic [7:0] t, input logic [3:0] e,
                                       input logic [31:0] p);
    logic [DW-1:0] d;
    d = '0;
    d[71:64]  = t;
    d[15:12]  = e;
    d[127:96] = p;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last, input logic dr, output int waits);
    s_tdata  = d;
    s_tlast  = last;
    drop     = dr;
    s_tvalid = 1'b1;
    waits    = 0;
    while (s_tready !== 1'b1 && waits < 200) begin
      step();
      waits++;
    end
    chk("send_bound", DW'(waits < 200), DW'(1));
    step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; drop = 1'b0; m_tready = 3'b111;
    s_tdata = '0; s_tkeep = 4'hF; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
    step(); step(); step();
    chk("rst_tvalid", DW'(m_tvalid), DW'(0));
    chk("rst_tready", DW'(s_tready), DW'(0));
    chk("rst_drop_count", DW'(drop_count), DW'(0));
    chk("rst_err_count", DW'(err_count), DW'(0));
    chk("rst_stat_drop", DW'(stat_drop), DW'(0));
    rst = 1'b0;
    step();
    chk("post_rst_tready", DW'(s_tready), DW'(1));

    // Single-beat completions routed by tag
    for (int t = 0; t < 3; t++) begin
      s_tuser = UW'(t + 5);
      send(mk(8'(t), 4'h0, 32'hA0 + 32'(t)), 1'b1, 1'b0, w);
      chk("route_tvalid", DW'(m_tvalid), DW'(1 << t));
      chk("route_tdata", m_tdata[t*DW +: DW], mk(8'(t), 4'h0, 32'hA0 + 32'(t)));
      chk("route_tlast", DW'(m_tlast[t]), DW'(1));
      chk("route_tuser", DW'(m_tuser[t*UW +: UW]), DW'(t + 5));
    end
    s_tvalid = 1'b0; s_tuser = '0;
    step();
    chk("route_idle_tvalid", DW'(m_tvalid), DW'(0));
    chk("route_drop_count", DW'(drop_count), DW'(0));

    // Later beats carry tag 1 but must follow beat 0 to output 2
    send(mk(8'h02, 4'h0, 32'hB0), 1'b0, 1'b0, w);
    chk("multi_b0", DW'(m_tvalid), DW'(3'b100));
    send(mk(8'h01, 4'h0, 32'hB1), 1'b0, 1'b0, w);
    chk("multi_b1", DW'(m_tvalid), DW'(3'b100));
    chk("multi_b1_data", m_tdata[2*DW +: DW], mk(8'h01, 4'h0, 32'hB1));
    send(mk(8'h01, 4'h0, 32'hB2), 1'b1, 1'b0, w);
    chk("multi_b2", DW'(m_tvalid), DW'(3'b100));
    chk("multi_b2_last", DW'(m_tlast[2]), DW'(1));
    s_tvalid = 1'b0;
    step();

    // Completion error code drops the frame
    send(mk(8'h00, 4'h1, 32'hC0), 1'b0, 1'b0, w);
    chk("err_b0_tvalid", DW'(m_tvalid), DW'(0));
    chk("err_stat_pulse", DW'(stat_drop), DW'(1));
    send(mk(8'h00, 4'h0, 32'hC1), 1'b1, 1'b0, w);
    chk("err_b1_nowait", DW'(w), DW'(0));
    chk("err_b1_tvalid", DW'(m_tvalid), DW'(0));
    chk("err_stat_end", DW'(stat_drop), DW'(0));
    chk("err_drop_count", DW'(drop_count), DW'(1));
    chk("err_err_count", DW'(err_count), DW'(1));

    // Tag 3 exceeds the output count
    send(mk(8'h03, 4'h0, 32'hD0), 1'b1, 1'b0, w);
    chk("oor_tvalid", DW'(m_tvalid), DW'(0));
    chk("oor_stat", DW'(stat_drop), DW'(1));
    chk("oor_drop_count", DW'(drop_count), DW'(2));
    chk("oor_err_count", DW'(err_count), DW'(1));
    send(mk(8'h01, 4'h0, 32'hD1), 1'b1, 1'b0, w);
    chk("oor_next_tvalid", DW'(m_tvalid), DW'(3'b010));
    s_tvalid = 1'b0;
    step();

    // Output 1 stalls during a 4-beat frame
    for (int i = 0; i < 4; i++) exp_d[i] = mk(8'h01, 4'h0, 32'hE0 + 32'(i));
    cap.delete();
    cap_en = 1'b1;
    m_tready = 3'b101;
    send(exp_d[0], 1'b0, 1'b0, w);
    chk("bp_a_tvalid", DW'(m_tvalid), DW'(3'b010));
    send(exp_d[1], 1'b0, 1'b0, w);
    chk("bp_full_tready", DW'(s_tready), DW'(0));
    s_tdata = exp_d[2]; s_tlast = 1'b0; s_tvalid = 1'b1;
    step(); step(); step();
    chk("bp_hold_tready", DW'(s_tready), DW'(0));
    chk("bp_hold_tvalid", DW'(m_tvalid), DW'(3'b010));
    chk("bp_hold_data", m_tdata[DW +: DW], exp_d[0]);
    m_tready = 3'b111;
    send(exp_d[2], 1'b0, 1'b0, w);
    send(exp_d[3], 1'b1, 1'b0, w);
    s_tvalid = 1'b0;
    step(); step(); step(); step();
    cap_en = 1'b0;
    chk("bp_count", DW'(cap.size()), DW'(4));
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] v;
      v = (i < cap.size()) ? cap[i] : '0;
      chk("bp_order", v, exp_d[i]);
    end

    // Drop input forces drops until the 4-bit counter saturates
    for (int i = 0; i < 15; i++) send(mk(8'h00, 4'h0, 32'hF0), 1'b1, 1'b1, w);
    s_tvalid = 1'b0; drop = 1'b0;
    step();
    chk("sat_drop_count", DW'(drop_count), DW'(4'hF));
    chk("sat_err_count", DW'(err_count), DW'(1));
    chk("sat_tvalid", DW'(m_tvalid), DW'(0));
    send(mk(8'h00, 4'h0, 32'hF1), 1'b1, 1'b1, w);
    s_tvalid = 1'b0; drop = 1'b0;
    chk("sat_no_wrap", DW'(drop_count), DW'(4'hF));

    enable = 1'b0;
    step();
    chk("enable_gate", DW'(s_tready), DW'(0));
    enable = 1'b1;
    step();

    // Reset in the middle of a frame to output 2
    send(mk(8'h02, 4'h0, 32'h90), 1'b0, 1'b0, w);
    chk("mid_b0_tvalid", DW'(m_tvalid), DW'(3'b100));
    s_tvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tvalid", DW'(m_tvalid), DW'(0));
    chk("mid_rst_tready", DW'(s_tready), DW'(0));
    chk("mid_rst_drop_count", DW'(drop_count), DW'(0));
    chk("mid_rst_err_count", DW'(err_count), DW'(0));
    send(mk(8'h00, 4'h0, 32'h91), 1'b1, 1'b0, w);
    chk("mid_new_b0_tvalid", DW'(m_tvalid), DW'(3'b001));
    chk("mid_new_b0_data", m_tdata[0 +: DW], mk(8'h00, 4'h0, 32'h91));
    s_tvalid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
